// File: rtl/fft32_pkg.sv
// ---------------------------------------------------------------------------
// fft32_pkg
// Shared definitions for the 32-point radix-2 FFT: the loader, the core and
// the stage-select control unit all import this package.
//   FFT_N       points per frame
//   FFT_LOG2N   index width
//   FFT_DATA_W  default width of each real / imaginary component
//   fft32_cplx_t  packed complex sample {re, im}
//   bitrev5()     5-bit index bit reversal
// ---------------------------------------------------------------------------
package fft32_pkg;

    localparam int FFT_N      = 32;
    localparam int FFT_LOG2N  = 5;
    localparam int FFT_DATA_W = 16;

    typedef struct packed {
        logic signed [FFT_DATA_W-1:0] re;
        logic signed [FFT_DATA_W-1:0] im;
    } fft32_cplx_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] i);
        return {i[0], i[1], i[2], i[3], i[4]};
    endfunction

endpackage

// File: rtl/fft32_sample_bank.sv
// ---------------------------------------------------------------------------
// fft32_sample_bank
// One N-entry sample store: single synchronous write port, asynchronous read
// port. Contents are not reset; the loader's full flags say what is valid.
//   clk    clock, rising edge
//   we     write enable
//   waddr  write address
//   wdata  write data ({re, im})
//   raddr  read address
//   rdata  read data, combinational from raddr
// ---------------------------------------------------------------------------
module fft32_sample_bank
    import fft32_pkg::*;
#(
    parameter int W = 2 * FFT_DATA_W
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [FFT_LOG2N-1:0] waddr,
    input  logic [W-1:0]         wdata,
    input  logic [FFT_LOG2N-1:0] raddr,
    output logic [W-1:0]         rdata
);

    logic [W-1:0] mem [FFT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft32_bitrev_loader.sv
// ---------------------------------------------------------------------------
// fft32_bitrev_loader
// Input stage of the 32-point FFT. Natural-order samples are written into one
// of two banks at bit-reversed addresses; a completed bank is then read out
// sequentially, which presents the frame in bit-reversed order. While one bank
// drains the other fills, so back-to-back frames run at one sample per cycle.
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   in_valid/ready   input handshake
//   in_re, in_im     input sample
//   in_flush         drop the partially filled frame
//   out_valid/ready  output handshake
//   out_re, out_im   output sample (0 while out_valid is low)
//   out_idx          natural-order index of the presented sample
//   out_last         final sample of a frame
//   frames_buffered  number of complete frames held (0..2)
// ---------------------------------------------------------------------------
module fft32_bitrev_loader
    import fft32_pkg::*;
#(
    parameter int DATA_W = FFT_DATA_W,
    parameter int N      = FFT_N,
    parameter int LOG2N  = FFT_LOG2N
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    input  logic              in_flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_re,
    output logic [DATA_W-1:0] out_im,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_last,
    output logic [1:0]        frames_buffered
);

    localparam int W = 2 * DATA_W;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    // The bit-reversal network is hard-wired for 32 points.
    if (N != FFT_N || LOG2N != FFT_LOG2N) begin : g_bad_size
        $error("fft32_bitrev_loader: only N=32, LOG2N=5 is supported");
    end

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [1:0]       full;
    logic [1:0]       full_nxt;
    logic [1:0]       fb_nxt;

    logic             in_fire;
    logic             wr_keep;
    logic             wr_done;
    logic             rd_fire;
    logic             rd_done;

    logic [1:0]       bank_we;
    logic [W-1:0]     bank_rdata [2];
    logic [W-1:0]     rd_word;

    // ---------------- handshake ----------------
    assign in_ready  = !full[wr_bank];
    assign in_fire   = in_valid && in_ready;
    // A sample that arrives together with a flush is accepted but dropped.
    assign wr_keep   = in_fire && !in_flush;
    assign wr_done   = wr_keep && (wr_cnt == LAST_IDX);

    assign out_valid = full[rd_bank];
    assign rd_fire   = out_valid && out_ready;
    assign rd_done   = rd_fire && (rd_cnt == LAST_IDX);

    // ---------------- sample banks ----------------
    assign bank_we[0] = wr_keep && (wr_bank == 1'b0);
    assign bank_we[1] = wr_keep && (wr_bank == 1'b1);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft32_sample_bank #(
            .W (W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[b]),
            .waddr (bitrev5(wr_cnt)),
            .wdata ({in_re, in_im}),
            .raddr (rd_cnt),
            .rdata (bank_rdata[b])
        );
    end

    // ---------------- read path ----------------
    assign rd_word  = rd_bank ? bank_rdata[1] : bank_rdata[0];
    assign out_re   = out_valid ? rd_word[W-1:DATA_W] : '0;
    assign out_im   = out_valid ? rd_word[DATA_W-1:0] : '0;
    assign out_idx  = bitrev5(rd_cnt);
    assign out_last = out_valid && (rd_cnt == LAST_IDX);

    // ---------------- full flags ----------------
    // A write can only complete into an empty bank and a drain can only finish
    // on a full one, so the two updates never target the same bit.
    always_comb begin
        full_nxt = full;
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        fb_nxt = {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            wr_cnt          <= '0;
            rd_cnt          <= '0;
            full            <= 2'b00;
            frames_buffered <= 2'd0;
        end else begin
            full            <= full_nxt;
            frames_buffered <= fb_nxt;

            if (in_flush) begin
                wr_cnt <= '0;
            end else if (in_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (rd_fire) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

endmodule
